// File: rtl/drive_sample_sequencer_if.sv
// Requester, sink and response signals of drive_sample_sequencer.
// The master side drives requests and the sink output q; the slave side is the sequencer.
interface drive_sample_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        a;
  logic                    a_valid;
  logic [WIDTH-1:0]        q;
  logic                    rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [WIDTH-1:0]        rsp_data;

  modport master (
    output req_valid, req_data, q,
    input  req_ready, a, a_valid, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, q,
    output req_ready, a, a_valid, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/drive_sample_sequencer.sv
// Round-robin sequencer sharing one drive port to a registered sink; returns the sampled q.
// Optional macro DRIVE_HOLD_EN: keep `a` at the last driven value instead of clearing it.
module drive_sample_sequencer #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DLY   = 1
) (
  input logic                    clk,
  input logic                    rst,
  drive_sample_sequencer_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DRIVE, S_SETTLE, S_SAMPLE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]       dly_cnt_q, dly_cnt_d;
  logic [IW-1:0]    id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             a_valid_q, a_valid_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [WIDTH-1:0] req_word [NREQ];
  logic [IW-1:0]    grant_id;
  logic             grant_found;
  logic             accept;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_word[gi]      = bus.req_data[gi*WIDTH +: WIDTH];
    assign bus.req_ready[gi] = accept && (grant_id == IW'(gi)) && !rst;
  end

  // Descending scan so the requester closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IW'((int'(rr_ptr_q) + k) % NREQ)]) begin
        grant_found = 1'b1;
        grant_id    = IW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // SAMPLE is the last busy cycle; accepting there gives back-to-back spacing of DLY+4.
  assign accept = grant_found && ((state_q == S_IDLE) || (state_q == S_SAMPLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      dly_cnt_q   <= '0;
      id_q        <= '0;
      data_q      <= '0;
      a_q         <= '0;
      a_valid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      dly_cnt_q   <= dly_cnt_d;
      id_q        <= id_d;
      data_q      <= data_d;
      a_q         <= a_d;
      a_valid_q   <= a_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_WAIT;
      S_WAIT:   if (dly_cnt_q == 3'd0) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_SAMPLE;
      S_SAMPLE: state_d = accept ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    dly_cnt_d   = dly_cnt_q;
    id_d        = id_q;
    data_d      = data_q;
    a_d         = a_q;
    a_valid_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      id_d      = grant_id;
      data_d    = req_word[grant_id];
      rr_ptr_d  = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
      dly_cnt_d = 3'(DLY);
    end
    case (state_q)
      S_WAIT: begin
        if (dly_cnt_q != 3'd0) dly_cnt_d = dly_cnt_q - 3'd1;
      end
      S_DRIVE: begin
        a_d       = data_q;
        a_valid_d = 1'b1;
      end
      S_SETTLE: begin
`ifdef DRIVE_HOLD_EN
        a_d = a_q;
`else
        a_d = '0;
`endif
      end
      S_SAMPLE: begin
        rsp_data_d  = bus.q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.a         = a_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_drive_sample_sequencer.sv
// Bench for drive_sample_sequencer: DLY=0 and DLY=1 instances, each with its own sink,
// checked every cycle against a timeline model built from the accept-edge latencies.
module tb_drive_sample_sequencer;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IW    = $clog2(NREQ);
  localparam int NCYC  = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = gi;
    logic rst       = 1'b1;
    logic done_flag = 1'b0;

    drive_sample_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_if ();

    drive_sample_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .DLY(D)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
    );

    // Registered sink.
    always @(posedge clk) bus_if.q <= bus_if.a;

    initial begin : stim
      int               ptr, free_at, granted, stage;
      logic [WIDTH-1:0] hold, last, exp_a;
      logic [NREQ-1:0]  pend, exp_ready;
      logic [WIDTH-1:0] pdata [NREQ];
      logic [NREQ*WIDTH-1:0] rd;
      int               drv_cyc[$];
      logic [WIDTH-1:0] drv_dat[$];
      int               rsp_cyc[$];
      int               rsp_idq[$];
      logic [WIDTH-1:0] rsp_datq[$];
      logic             prev_rst, exp_av, exp_rv, rst_now;
      string            pfx;

      ptr = 0; free_at = 0; granted = -1; stage = 0;
      hold = '0; pend = '0; prev_rst = 1'b1;
      for (int i = 0; i < NREQ; i++) pdata[IW'(i)] = '0;
      pfx = $sformatf("dly%0d", D);
      bus_if.req_valid = '0;
      bus_if.req_data  = '0;

      // Iteration c sits at the negedge before edge c; outputs reflect edge c-1.
      for (int c = 1; c <= NCYC; c++) begin
        @(negedge clk);
        exp_av = 1'b0;
        last   = '0;
        if (drv_cyc.size() != 0 && drv_cyc[0] == c - 1) begin
          exp_av = 1'b1;
          last   = drv_dat.pop_front();
          drv_cyc.delete(0);
          hold   = last;
        end
`ifdef DRIVE_HOLD_EN
        exp_a = hold;
`else
        exp_a = last;
`endif
        check_eq({pfx, " a_valid"}, 32'(bus_if.a_valid), 32'(exp_av));
        check_eq({pfx, " a"}, 32'(bus_if.a), 32'(exp_a));
        exp_rv = (rsp_cyc.size() != 0 && rsp_cyc[0] == c - 1);
        check_eq({pfx, " rsp_valid"}, 32'(bus_if.rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
          check_eq({pfx, " rsp_id"}, 32'(bus_if.rsp_id), 32'(rsp_idq[0]));
          check_eq({pfx, " rsp_data"}, 32'(bus_if.rsp_data), 32'(rsp_datq[0]));
          rsp_cyc.delete(0); rsp_idq.delete(0); rsp_datq.delete(0);
        end
        if (prev_rst) begin
          check_eq({pfx, " rst rsp_id"}, 32'(bus_if.rsp_id), 32'd0);
          check_eq({pfx, " rst rsp_data"}, 32'(bus_if.rsp_data), 32'd0);
        end

        // The previously granted requester drops its request and scrambles its data.
        if (granted >= 0) begin
          pend[IW'(granted)]  = 1'b0;
          pdata[IW'(granted)] = WIDTH'($urandom);
          granted = -1;
        end
        rst_now = 1'b0;
        if (c < 5) begin
          rst_now = 1'b1;
        end else if (c < 40) begin
          if (!pend[0]) begin pend[0] = 1'b1; pdata[0] = WIDTH'(8'h01); end
        end else if (c < 100) begin
          for (int i = 0; i < NREQ; i++)
            if (!pend[IW'(i)]) begin pend[IW'(i)] = 1'b1; pdata[IW'(i)] = WIDTH'(8'h10 + i); end
        end else if (c < 160) begin
          if (stage == 0 && pend == '0) begin
            pend[3] = 1'b1; pdata[3] = WIDTH'($urandom); stage = 1;
          end else if (stage == 1 && !pend[3]) begin
            pend[1] = 1'b1; pdata[1] = WIDTH'($urandom); stage = 2;
          end
        end else begin
          if (drv_cyc.size() != 0 && $urandom_range(31) == 0) rst_now = 1'b1;
          else if ($urandom_range(127) == 0) rst_now = 1'b1;
          for (int i = 0; i < NREQ; i++)
            if (!pend[IW'(i)] && $urandom_range(3) == 0) begin
              pend[IW'(i)] = 1'b1; pdata[IW'(i)] = WIDTH'($urandom);
            end
        end

        rd = '0;
        for (int i = 0; i < NREQ; i++) rd = {pdata[IW'(i)], rd[NREQ*WIDTH-1:WIDTH]};
        rst = rst_now;
        bus_if.req_valid = pend;
        bus_if.req_data  = rd;
        #1;

        exp_ready = '0;
        if (rst_now) begin
          drv_cyc.delete(); drv_dat.delete();
          rsp_cyc.delete(); rsp_idq.delete(); rsp_datq.delete();
          ptr = 0; free_at = c + 1; hold = '0;
        end else if (c >= free_at && pend != '0) begin
          for (int k = NREQ - 1; k >= 0; k--)
            if (pend[IW'((ptr + k) % NREQ)]) granted = (ptr + k) % NREQ;
          exp_ready = NREQ'(1) << granted;
          drv_cyc.push_back(c + D + 2);
          drv_dat.push_back(pdata[IW'(granted)]);
          rsp_cyc.push_back(c + D + 4);
          rsp_idq.push_back(granted);
          rsp_datq.push_back(pdata[IW'(granted)]);
          free_at = c + D + 4;
          ptr = (granted + 1) % NREQ;
        end
        check_eq({pfx, " req_ready"}, 32'(bus_if.req_ready), 32'(exp_ready));
        prev_rst = rst_now;
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 3 * NCYC && !(g_inst[0].done_flag && g_inst[1].done_flag); t++)
      @(posedge clk);
    check_eq("instances done", 32'({g_inst[1].done_flag, g_inst[0].done_flag}), 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
